// File: rtl/mp_pkg.sv
// Shared definitions for the shift-add multiplier controller: select codes,
// FSM states and the per-state select decode.
package mp_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [1:0] SEL_LOAD = 2'b00;
    localparam logic [1:0] SEL_OP   = 2'b01;
    localparam logic [1:0] SEL_HOLD = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        TEST    = 3'd2,
        ADD     = 3'd3,
        SHIFT   = 3'd4,
        CAPTURE = 3'd5,
        RESULT  = 3'd6
    } state_t;

    typedef struct packed {
        logic [1:0] b;
        logic [1:0] q;
        logic [1:0] a;
        logic [1:0] n;
    } sel_bundle_t;

    // Selects are a pure function of state; the caller registers them.
    function automatic sel_bundle_t sel_for_state(input state_t s);
        sel_bundle_t sb;
        sb = '{b: SEL_HOLD, q: SEL_HOLD, a: SEL_HOLD, n: SEL_HOLD};
        case (s)
            LOAD:    sb = '{b: SEL_LOAD, q: SEL_LOAD, a: SEL_LOAD, n: SEL_LOAD};
            ADD:     sb.a = SEL_OP;
            SHIFT:   sb = '{b: SEL_OP, q: SEL_OP, a: SEL_HOLD, n: SEL_OP};
            default: sb = '{b: SEL_HOLD, q: SEL_HOLD, a: SEL_HOLD, n: SEL_HOLD};
        endcase
        return sb;
    endfunction

endpackage

// File: rtl/mp_control.sv
// Sequencing FSM for the shift-add multiplier datapath: load, WIDTH test/add/shift
// iterations, product capture and a valid/ready result hand-off.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start, all selects HOLD
// LOAD    | datapath loads operands, A cleared, N loaded with WIDTH
// TEST    | inspect N and Q[0]; choose ADD, SHIFT or CAPTURE
// ADD     | A += B
// SHIFT   | B <<= 1, Q >>= 1, N -= 1, shift counter advances
// CAPTURE | product <= A
// RESULT  | product_valid high until product_ready
module mp_control
    import mp_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    input  logic [WIDTH-1:0]     qsub0,
    input  logic [WIDTH-1:0]     n_eq_0,
    input  logic [2*WIDTH-1:0]   resultado,
    output logic [1:0]           B_sel,
    output logic [1:0]           Q_sel,
    output logic [1:0]           A_sel,
    output logic [1:0]           N_sel,
    output logic [2*WIDTH-1:0]   product,
    output logic                 product_valid,
    input  logic                 product_ready,
    output logic                 err
);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    sel_bundle_t        r_sel;
    sel_bundle_t        w_sel_next;
    logic [2*WIDTH-1:0] r_product;
    logic               r_err;

    logic w_cnt_done;
    logic w_n_zero;
    logic w_set_err;
    logic w_accept;
    logic w_unused_q;

    assign w_cnt_done = (r_cnt == CNT_W'(WIDTH));
    assign w_n_zero   = (n_eq_0 == '0);
    assign w_accept   = (r_state == IDLE) && start;
    // Only the current multiplier bit matters to sequencing.
    assign w_unused_q = ^qsub0[WIDTH-1:1];

    always_comb begin
        w_next    = r_state;
        w_set_err = 1'b0;
        case (r_state)
            IDLE:    if (start) w_next = LOAD;
            LOAD:    w_next = TEST;
            TEST: begin
                if (w_n_zero && w_cnt_done) begin
                    w_next = CAPTURE;
                end else if (w_n_zero || w_cnt_done) begin
                    w_set_err = 1'b1;
                    w_next    = CAPTURE;
                end else if (qsub0[0]) begin
                    w_next = ADD;
                end else begin
                    w_next = SHIFT;
                end
            end
            ADD:     w_next = SHIFT;
            SHIFT:   w_next = TEST;
            CAPTURE: w_next = RESULT;
            RESULT:  if (product_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_sel_next = sel_for_state(w_next);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_sel     <= '{b: SEL_HOLD, q: SEL_HOLD, a: SEL_HOLD, n: SEL_HOLD};
            r_product <= '0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state <= w_next;
            r_sel   <= w_sel_next;
            if (r_state == CAPTURE) begin
                r_product <= resultado;
            end
            if (w_accept) begin
                r_err <= 1'b0;
            end else if (w_set_err) begin
                r_err <= 1'b1;
            end
            if (w_accept) begin
                r_cnt <= '0;
            end else if (r_state == SHIFT && !w_cnt_done) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign busy          = (r_state != IDLE);
    assign product_valid = (r_state == RESULT);
    assign product       = r_product;
    assign err           = r_err;
    assign B_sel         = r_sel.b;
    assign Q_sel         = r_sel.q;
    assign A_sel         = r_sel.a;
    assign N_sel         = r_sel.n;

endmodule

// File: tb/tb_mp_control.sv
// Bench for mp_control with a behavioural edge-sensitive datapath model and a
// scoreboard of expected product / err / latency per multiply.
module tb_mp_control;
    import mp_pkg::*;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           busy;
    logic [W-1:0]   qsub0;
    logic [W-1:0]   n_eq_0;
    logic [2*W-1:0] resultado;
    logic [1:0]     B_sel, Q_sel, A_sel, N_sel;
    logic [2*W-1:0] product;
    logic           product_valid;
    logic           product_ready;
    logic           err;

    mp_control #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .qsub0(qsub0), .n_eq_0(n_eq_0), .resultado(resultado),
        .B_sel(B_sel), .Q_sel(Q_sel), .A_sel(A_sel), .N_sel(N_sel),
        .product(product), .product_valid(product_valid),
        .product_ready(product_ready), .err(err)
    );

    always #5 clk = ~clk;

    // Datapath model: acts on LOAD, and on a transition into OP.
    logic [W-1:0]   op_x, op_y;
    logic           fault_n;
    logic [2*W-1:0] dp_a, dp_b;
    logic [W-1:0]   dp_q, dp_n;
    logic [1:0]     pv_b = SEL_HOLD, pv_q = SEL_HOLD, pv_a = SEL_HOLD, pv_n = SEL_HOLD;

    always @(posedge clk) begin
        pv_b <= B_sel; pv_q <= Q_sel; pv_a <= A_sel; pv_n <= N_sel;
        if (B_sel == SEL_LOAD) dp_b <= {{W{1'b0}}, op_x};
        else if (B_sel == SEL_OP && pv_b != SEL_OP) dp_b <= dp_b << 1;
        if (Q_sel == SEL_LOAD) dp_q <= op_y;
        else if (Q_sel == SEL_OP && pv_q != SEL_OP) dp_q <= dp_q >> 1;
        if (A_sel == SEL_LOAD) dp_a <= '0;
        else if (A_sel == SEL_OP && pv_a != SEL_OP) dp_a <= dp_a + dp_b;
        if (N_sel == SEL_LOAD) dp_n <= W;
        else if (N_sel == SEL_OP && pv_n != SEL_OP) dp_n <= dp_n - 1;
    end

    assign qsub0     = dp_q;
    assign n_eq_0    = fault_n ? W'(5) : dp_n;
    assign resultado = dp_a;

    // Protocol monitor: repeated OP on a line and any A-add activity.
    int op_repeat = 0;
    int a_op_cnt  = 0;
    logic [1:0] mb = SEL_HOLD, mq = SEL_HOLD, ma = SEL_HOLD, mn = SEL_HOLD;
    always @(negedge clk) begin
        if ((B_sel == SEL_OP && mb == SEL_OP) || (Q_sel == SEL_OP && mq == SEL_OP) ||
            (A_sel == SEL_OP && ma == SEL_OP) || (N_sel == SEL_OP && mn == SEL_OP))
            op_repeat++;
        if (A_sel == SEL_OP) a_op_cnt++;
        mb <= B_sel; mq <= Q_sel; ma <= A_sel; mn <= N_sel;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [2*W-1:0] prod;
        logic           err;
        int             lat;
    } exp_t;
    exp_t sb_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one multiply and score its result; leaves the DUT in RESULT.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic fault);
        exp_t e;
        int   lat;
        op_x    = x;
        op_y    = y;
        fault_n = fault;
        e.prod  = 64'(x) * 64'(y);
        e.err   = fault;
        e.lat   = 3 + 2 * W + $countones(y);
        sb_q.push_back(e);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_val("busy_after_accept", 64'(busy), 64'd1);
        chk_val("err_clr_on_start", 64'(err), 64'd0);
        lat = 0;
        while (!product_valid && lat < 400) begin
            tick();
            lat++;
        end
        e = sb_q.pop_front();
        chk_val("latency", 64'(lat), 64'(e.lat));
        chk_val("product", product, e.prod);
        chk_val("err", 64'(err), 64'(e.err));
    endtask

    task automatic check_idle(input string tag);
        chk_val({tag, "_busy"}, 64'(busy), 64'd0);
        chk_val({tag, "_valid"}, 64'(product_valid), 64'd0);
        chk_val({tag, "_sels"}, 64'({B_sel, Q_sel, A_sel, N_sel}), 64'hFF);
    endtask

    initial begin
        logic [2*W-1:0] held;
        rst = 1'b1; start = 1'b0; product_ready = 1'b1;
        op_x = '0; op_y = '0; fault_n = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check_idle("reset");
        chk_val("reset_product", product, 64'd0);
        chk_val("reset_err", 64'(err), 64'd0);

        run_op(32'd3, 32'd5, 1'b0);
        tick();
        check_idle("post_3x5");

        a_op_cnt = 0;
        run_op(32'hFFFF_FFFF, 32'd0, 1'b0);
        chk_val("no_add_when_y0", 64'(a_op_cnt), 64'd0);
        tick();

        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        tick();
        chk_val("no_repeated_op", 64'(op_repeat), 64'd0);

        for (int i = 0; i < 3; i++) begin
            run_op($urandom, $urandom, 1'b0);
            tick();
        end

        // Backpressure with start pulses while in RESULT.
        product_ready = 1'b0;
        run_op(32'd1234, 32'd5678, 1'b0);
        held = product;
        for (int i = 0; i < 10; i++) begin
            start = (i % 2 == 0);
            tick();
            chk_val("bp_valid", 64'(product_valid), 64'd1);
            chk_val("bp_product", product, held);
        end
        start = 1'b0;
        product_ready = 1'b1;
        tick();
        check_idle("bp_release");
        tick();
        chk_val("bp_start_ignored", 64'(busy), 64'd0);

        // Reset mid-operation.
        op_x = 32'd99; op_y = 32'd77; fault_n = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 19; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("midop_rst");
        run_op(32'd7, 32'd6, 1'b0);
        tick();

        // N stuck at 5: counter reaches WIDTH while N is non-zero.
        run_op(32'd11, 32'd13, 1'b1);
        tick();
        chk_val("err_sticky_idle", 64'(err), 64'd1);
        run_op(32'd2, 32'd9, 1'b0);
        tick();
        check_idle("final");
        chk_val("no_repeated_op_all", 64'(op_repeat), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
